// File: rtl/cpu_fetch_unit.sv
// Fetch/execute sequencer of the 16-bit multi-cycle CPU: PC, IR, execute-state bit, N/Z flags.
// Optional macro CPU_FETCH_STALL_CNT_EN adds a saturating fetch-stall counter on StallCnt.
module cpu_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  PS,
    input  logic        IR_L,
    input  logic        NS,
    input  logic [15:0] Offset,
    input  logic [15:0] BusD,
    input  logic        FlagLd,
    input  logic        N_in,
    input  logic        Z_in,
    input  logic        IMemAck,
    input  logic [15:0] IMemData,
    output logic        IMemReq,
    output logic [15:0] IMemAddr,
    output logic [15:0] PC,
    output logic [15:0] IR,
    output logic        State,
    output logic        N,
    output logic        Z,
    output logic        ExecEn
`ifdef CPU_FETCH_STALL_CNT_EN
    ,
    output logic [15:0] StallCnt
`endif
);

    typedef enum logic {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] pc_nxt;

    assign IMemAddr = PC;

    always_comb begin
        state_nxt = state;
        IMemReq   = 1'b0;
        ExecEn    = 1'b0;
        case (state)
            FETCH: begin
                IMemReq = 1'b1;
                if (IMemAck) state_nxt = EXEC;
            end
            EXEC: begin
                ExecEn = 1'b1;
                if (IR_L) state_nxt = FETCH;
            end
            default: state_nxt = FETCH;
        endcase
        // The handshake and datapath commit must be quiet during the reset cycle itself.
        if (rst) begin
            IMemReq = 1'b0;
            ExecEn  = 1'b0;
        end
    end

    always_comb begin
        pc_nxt = PC;
        case (PS)
            2'b01:   pc_nxt = PC + 16'd1;
            2'b10:   pc_nxt = PC + Offset;
            2'b11:   pc_nxt = BusD;
            default: pc_nxt = PC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            PC    <= RESET_PC;
            IR    <= 16'h0000;
            State <= 1'b0;
            N     <= 1'b0;
            Z     <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                FETCH: begin
                    if (IMemAck) begin
                        IR    <= IMemData;
                        State <= 1'b0;
                    end
                end
                EXEC: begin
                    PC <= pc_nxt;
                    if (FlagLd) begin
                        N <= N_in;
                        Z <= Z_in;
                    end
                    State <= IR_L ? 1'b0 : NS;
                end
                default: ;
            endcase
        end
    end

`ifdef CPU_FETCH_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            StallCnt <= 16'h0000;
        end else if (state == FETCH && !IMemAck && StallCnt != 16'hFFFF) begin
            StallCnt <= StallCnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Scoreboard bench for cpu_fetch_unit: directed scenarios then random traffic against a cycle model.
module tb_cpu_fetch_unit;

    localparam logic [15:0] RST_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  PS = 2'b00;
    logic        IR_L = 1'b0, NS = 1'b0, FlagLd = 1'b0, N_in = 1'b0, Z_in = 1'b0, IMemAck = 1'b0;
    logic [15:0] Offset = '0, BusD = '0, IMemData = '0;
    logic        IMemReq, State, N, Z, ExecEn;
    logic [15:0] IMemAddr, PC, IR;
`ifdef CPU_FETCH_STALL_CNT_EN
    logic [15:0] StallCnt;
`endif

    cpu_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .PS(PS), .IR_L(IR_L), .NS(NS), .Offset(Offset), .BusD(BusD),
        .FlagLd(FlagLd), .N_in(N_in), .Z_in(Z_in), .IMemAck(IMemAck), .IMemData(IMemData),
        .IMemReq(IMemReq), .IMemAddr(IMemAddr), .PC(PC), .IR(IR), .State(State),
        .N(N), .Z(Z), .ExecEn(ExecEn)
`ifdef CPU_FETCH_STALL_CNT_EN
        , .StallCnt(StallCnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic [1:0]  ps;
        logic        irl, ns, fld, nin, zin, ack;
        logic [15:0] off, busd, data;
    } stim_t;

    typedef struct packed {
        logic        req, exe, st, n, z;
        logic [15:0] pc, ir, sc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    // Reference model: architectural state of the front end, advanced once per clock.
    logic        m_exec = 1'b0, m_st = 1'b0, m_n = 1'b0, m_z = 1'b0;
    logic [15:0] m_pc = RST_PC, m_ir = 16'h0000, m_sc = 16'h0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    task automatic step(input stim_t s);
        exp_t e;
        @(posedge clk);
        #1;
        rst = s.rst; PS = s.ps; IR_L = s.irl; NS = s.ns; FlagLd = s.fld;
        N_in = s.nin; Z_in = s.zin; IMemAck = s.ack; Offset = s.off; BusD = s.busd; IMemData = s.data;
        e.req = !s.rst && !m_exec;
        e.exe = !s.rst && m_exec;
        e.st = m_st; e.n = m_n; e.z = m_z; e.pc = m_pc; e.ir = m_ir; e.sc = m_sc;
        exp_q.push_back(e);
        if (s.rst) begin
            m_exec = 0; m_pc = RST_PC; m_ir = 0; m_st = 0; m_n = 0; m_z = 0; m_sc = 0;
        end else if (!m_exec) begin
            if (s.ack) begin
                m_ir = s.data; m_st = 0; m_exec = 1;
            end else if (m_sc != 16'hFFFF) begin
                m_sc = m_sc + 1;
            end
        end else begin
            if (s.ps == 2'd1) m_pc = 16'((32'(m_pc) + 1) % 65536);
            else if (s.ps == 2'd2) m_pc = 16'((32'(m_pc) + 32'(s.off)) % 65536);
            else if (s.ps == 2'd3) m_pc = s.busd;
            if (s.fld) begin m_n = s.nin; m_z = s.zin; end
            if (s.irl) begin m_st = 0; m_exec = 0; end
            else m_st = s.ns;
        end
    endtask

    task automatic do_fetch(input logic [15:0] d);
        stim_t s;
        s = idle(); s.ack = 1; s.data = d;
        step(s);
    endtask

    task automatic do_exec(input logic [1:0] ps, input logic [15:0] off, input logic [15:0] busd,
                           input logic irl, input logic ns, input logic fld, input logic nin,
                           input logic zin);
        stim_t s;
        s = idle(); s.ps = ps; s.off = off; s.busd = busd; s.irl = irl; s.ns = ns;
        s.fld = fld; s.nin = nin; s.zin = zin;
        step(s);
    endtask

    // Monitor: one expected entry per cycle, compared mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("imem_req", 32'(IMemReq), 32'(e.req));
            chk("exec_en", 32'(ExecEn), 32'(e.exe));
            if (IMemReq) chk("imem_addr", 32'(IMemAddr), 32'(e.pc));
            chk("pc", 32'(PC), 32'(e.pc));
            chk("ir", 32'(IR), 32'(e.ir));
            chk("state", 32'(State), 32'(e.st));
            chk("flags", {30'd0, N, Z}, {30'd0, e.n, e.z});
`ifdef CPU_FETCH_STALL_CNT_EN
            chk("stall_cnt", 32'(StallCnt), 32'(e.sc));
`endif
        end
    end

    initial begin
        stim_t s;
        s = idle(); s.rst = 1;
        step(s);
        step(s);
        // Zero-wait fetches with PC+1: addresses 0,1,2.
        for (int i = 0; i < 3; i++) begin
            do_fetch(16'h1000 + 16'(i));
            do_exec(2'b01, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        // Three wait cycles then ack.
        for (int i = 0; i < 3; i++) step(idle());
        do_fetch(16'hBEEF);
        chk("delayed_ir", 32'(IR), 32'h0000_1002);
`ifdef CPU_FETCH_STALL_CNT_EN
        chk("stall_cnt_3", 32'(StallCnt), 32'd3);
`endif
        do_exec(2'b11, 16'h0, 16'h0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        do_fetch(16'h2222);
        chk("ir_loaded", 32'(IR), 32'h0000_BEEF);
        chk("pc_busd_10", 32'(PC), 32'h0010);
        do_exec(2'b10, 16'hFFF0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        do_fetch(16'h3333);
        chk("pc_offset_wrap", 32'(PC), 32'h0000);
        do_exec(2'b11, 16'h0, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        do_fetch(16'h4444);
        chk("pc_jump", 32'(IMemAddr), 32'h1234);
        // Two execute cycles: State 0 then 1.
        do_exec(2'b00, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        do_exec(2'b11, 16'h0, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("state_second_exec", 32'(State), 32'd1);
        chk("ir_held", 32'(IR), 32'h0000_4444);
        // Flags hold through fetch while N_in/Z_in toggle; PC FFFF+1 wraps.
        s = idle(); s.fld = 1; s.nin = 0; s.zin = 1;
        step(s);
        chk("state_fetch", 32'(State), 32'd0);
        chk("flags_set", {30'd0, N, Z}, 32'b10);
        s.ack = 1; s.data = 16'h5555; s.nin = 1; s.zin = 1;
        step(s);
        chk("flags_held", {30'd0, N, Z}, 32'b10);
        do_exec(2'b01, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        do_fetch(16'h6666);
        chk("pc_ffff_wrap", 32'(PC), 32'h0000);
        do_exec(2'b11, 16'h0, 16'h4444, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        // Reset while requesting, with ack in the same cycle.
        s = idle(); s.rst = 1; s.ack = 1; s.data = 16'hABCD;
        step(s);
        step(idle());
        chk("rst_fetch_ir", 32'(IR), 32'h0);
        chk("rst_fetch_pc", 32'(PC), 32'(RST_PC));
        do_fetch(16'h7777);
        // Reset during EXEC: no PC or flag update.
        s = idle(); s.rst = 1; s.ps = 2'b11; s.busd = 16'h9999; s.fld = 1; s.nin = 1; s.zin = 1;
        step(s);
        step(idle());
        chk("rst_exec_pc", 32'(PC), 32'(RST_PC));
        chk("rst_exec_flags", {30'd0, N, Z}, 32'b00);
        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            s.rst  = ($urandom_range(0, 49) == 0);
            s.ps   = 2'($urandom_range(0, 3));
            s.irl  = ($urandom_range(0, 9) < 7);
            s.ns   = 1'($urandom);
            s.fld  = 1'($urandom);
            s.nin  = 1'($urandom);
            s.zin  = 1'($urandom);
            s.ack  = ($urandom_range(0, 9) < 6);
            s.off  = 16'($urandom);
            s.busd = 16'($urandom);
            s.data = 16'($urandom);
            step(s);
        end
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
